correlator_readout_scheduler: RTL

Sequences one integration period of the correlator array. On each integration tick it snapshots the packed pulse-counter/correlator bus, issues a one-cycle clear to the counters, and streams the snapshot as a framed byte packet to the UART transmitter over a valid/ready handshake. It sits between the integration clock generator, the `pulse_counter` array and the byte-wide UART TX.

---
 rtl/correlator_readout_scheduler.sv | 88 ++++++++
 1 files changed

// File: rtl/correlator_readout_scheduler.sv
// correlator_readout_scheduler: snapshots the counter bus on each integration tick and streams it as a framed, checksummed byte packet
module correlator_readout_scheduler #(
   parameter int RESOLUTION      = 16,
   parameter int NUM_INPUTS      = 8,
   parameter int NUM_CORRELATORS = NUM_INPUTS*(NUM_INPUTS-1)/2,
   parameter int NUM_WORDS       = NUM_INPUTS+NUM_CORRELATORS,
   parameter int NUM_BYTES       = NUM_WORDS*RESOLUTION/8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic                            integration_clk_pulse,
   input  logic [RESOLUTION*NUM_WORDS-1:0] pulse_t,
   output logic                            reset_correlator,
   output logic [7:0]                      tx_data,
   output logic                            tx_valid,
   input  logic                            tx_ready,
   output logic                            busy,
   output logic                            overrun,
   output logic [7:0]                      frame_seq
);
   localparam int SW = RESOLUTION*NUM_WORDS;
   localparam int IW = $clog2(NUM_BYTES);
   typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} state_t;
   state_t        state;
   logic [SW-1:0] snap;
   logic [7:0]    csum;
   logic [IW-1:0] idx;
   logic          tick;
   logic          hs;
   assign tick = integration_clk_pulse && enable;
   assign hs   = tx_valid && tx_ready;
   assign busy = state != IDLE;
   // frame sequencer; the snapshot shifts down a byte per accepted DATA byte so the next byte is always at [15:8]
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         tx_valid         <= 1'b0;
         tx_data          <= 8'h00;
         reset_correlator <= 1'b0;
         overrun          <= 1'b0;
         frame_seq        <= 8'hFF;
         snap             <= '0;
         csum             <= 8'h00;
         idx              <= '0;
      end else begin
         reset_correlator <= tick;
         if (!enable) overrun <= 1'b0;
         else if (tick && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (tick) begin
               snap      <= pulse_t;
               frame_seq <= frame_seq + 8'd1;
               csum      <= 8'h00;
               tx_valid  <= 1'b1;
               tx_data   <= 8'hA5;
               state     <= SYNC;
            end
            SYNC: if (hs) begin
               tx_data <= frame_seq;
               state   <= SEQ;
            end
            SEQ: if (hs) begin
               csum    <= csum + tx_data;
               tx_data <= snap[7:0];
               idx     <= '0;
               state   <= DATA;
            end
            DATA: if (hs) begin
               csum <= csum + tx_data;
               snap <= snap >> 8;
               if (idx == IW'(NUM_BYTES-1)) begin
                  tx_data <= csum + tx_data;
                  state   <= CSUM;
               end else begin
                  tx_data <= snap[15:8];
                  idx     <= idx + IW'(1);
               end
            end
            CSUM: if (hs) begin
               tx_valid <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
